// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one buart transmitter between NREQ byte-stream
// requesters. Round-robin arbitration at message boundaries, the grant is
// held until the byte flagged req_last has been written, and an owner that
// goes silent for LOCK_TIMEOUT cycles loses the lock.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NREQ         = 2,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     grant,
    output logic                uart_wr,
    output logic [7:0]          uart_tx_data,
    input  logic                uart_busy,
    output logic                timeout_evt
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    // Counter value seen in the last idle LOAD cycle before release.
    localparam logic [CW-1:0] CNT_LAST   = CW'(LOCK_TIMEOUT - 1);
    // Saturation ceiling: the counter never wraps.
    localparam logic [CW-1:0] CNT_MAX    = CW'(LOCK_TIMEOUT);
    // Pointer starts at the top so requester 0 wins the first arbitration.
    localparam logic [OW-1:0] OWNER_INIT = OW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t             state_r,      state_s;
    logic [OW-1:0]      owner_r,      owner_s;
    logic [OW-1:0]      last_owner_r, last_owner_s;
    logic [NREQ-1:0]    grant_r,      grant_s;
    logic               uart_wr_r,    uart_wr_s;
    logic [7:0]         tx_data_r,    tx_data_s;
    logic               tevt_r,       tevt_s;
    logic [CW-1:0]      cnt_r,        cnt_s;
    logic               last_flag_r,  last_flag_s;

    logic [NREQ-1:0]    upper_s;
    logic [NREQ-1:0]    masked_s;
    logic [NREQ-1:0]    cand_s;
    logic [OW-1:0]      pick_s;

    logic               owner_valid_s;
    logic               owner_last_s;
    logic [7:0]         owner_byte_s;

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        for (int j = 0; j < NREQ; j++) begin
            v[j] = (idx == OW'(j));
        end
        return v;
    endfunction

    // Round-robin pick: lowest valid index above last_owner, else lowest valid index overall.
    always_comb begin
        upper_s = '0;
        for (int j = 0; j < NREQ; j++) begin
            upper_s[j] = (OW'(j) > last_owner_r);
        end
        masked_s = req_valid & upper_s;
        cand_s   = (|masked_s) ? masked_s : req_valid;
        pick_s   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            pick_s = cand_s[j] ? OW'(j) : pick_s;
        end
    end

    // Select the current owner's valid/last/byte with an AND-OR mux.
    always_comb begin
        owner_valid_s = 1'b0;
        owner_last_s  = 1'b0;
        owner_byte_s  = 8'h00;
        for (int j = 0; j < NREQ; j++) begin
            owner_valid_s = owner_valid_s | (req_valid[j] & (owner_r == OW'(j)));
            owner_last_s  = owner_last_s  | (req_last[j]  & (owner_r == OW'(j)));
            owner_byte_s  = owner_byte_s  | (req_data[8*j +: 8] & {8{owner_r == OW'(j)}});
        end
    end

    // Only the lock owner may be ready, only in LOAD, only while buart is idle.
    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            req_ready[j] = (state_r == ST_LOAD) && !uart_busy && !reset && (owner_r == OW'(j));
        end
    end

    // Next-state and next-output logic of the IDLE/LOAD/GUARD controller.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        grant_s      = grant_r;
        uart_wr_s    = 1'b0;
        tx_data_s    = tx_data_r;
        tevt_s       = 1'b0;
        cnt_s        = cnt_r;
        last_flag_s  = last_flag_r;

        case (state_r)
            ST_IDLE: begin
                // Arbitration cycle: no byte is accepted here.
                if (|req_valid) begin
                    owner_s = pick_s;
                    grant_s = onehot(pick_s);
                    cnt_s   = '0;
                    state_s = ST_LOAD;
                end else begin
                    grant_s = '0;
                end
            end

            ST_LOAD: begin
                if (owner_valid_s && !uart_busy) begin
                    // Transfer wins over a timeout reached in the same cycle.
                    uart_wr_s   = 1'b1;
                    tx_data_s   = owner_byte_s;
                    last_flag_s = owner_last_s;
                    cnt_s       = '0;
                    state_s     = ST_GUARD;
                end else if (!owner_valid_s) begin
                    if (cnt_r >= CNT_LAST) begin
                        // Owner went silent: drop the lock and advance the pointer.
                        grant_s      = '0;
                        last_owner_s = owner_r;
                        tevt_s       = 1'b1;
                        cnt_s        = '0;
                        state_s      = ST_IDLE;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + 1'b1;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else begin
                    // Owner has a byte but buart is busy: wait, counter holds.
                    cnt_s = cnt_r;
                end
            end

            ST_GUARD: begin
                // One cycle covering the lag between wr and busy rising.
                if (last_flag_r) begin
                    grant_s      = '0;
                    last_owner_s = owner_r;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_LOAD;
                end
            end

            default: begin
                // Unreachable encoding: recover to a released, idle arbiter.
                grant_s = '0;
                cnt_s   = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Register all controller state and outputs; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= '0;
            last_owner_r <= OWNER_INIT;
            grant_r      <= '0;
            uart_wr_r    <= 1'b0;
            tx_data_r    <= 8'h00;
            tevt_r       <= 1'b0;
            cnt_r        <= '0;
            last_flag_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            grant_r      <= grant_s;
            uart_wr_r    <= uart_wr_s;
            tx_data_r    <= tx_data_s;
            tevt_r       <= tevt_s;
            cnt_r        <= cnt_s;
            last_flag_r  <= last_flag_s;
        end
    end

    assign grant        = grant_r;
    assign uart_wr      = uart_wr_r;
    assign uart_tx_data = tx_data_r;
    assign timeout_evt  = tevt_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by a
// randomized message mix, checked against a message-level reference model
// (per-requester byte queues, round-robin over non-empty queues, buart busy model).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;
    localparam int TO   = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     grant;
    logic                uart_wr;
    logic [7:0]          uart_tx_data;
    logic                uart_busy;
    logic                timeout_evt;

    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .uart_wr      (uart_wr),
        .uart_tx_data (uart_tx_data),
        .uart_busy    (uart_busy),
        .timeout_evt  (timeout_evt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: {last, byte} per pending byte, per requester.
    logic [8:0] q [NREQ][$];
    logic [7:0] wire_q [$];
    int  gap_left [NREQ];
    int  busy_left = 0, busy_len = 0;
    bit  rand_busy = 0, rand_gaps = 0;
    int  max_gap = 0;
    bit  exp_wr = 0;
    logic [7:0] exp_data = 8'h00;
    bit  in_msg = 0;
    int  msg_owner = 0;
    int  rr_last = NREQ - 1;
    int  cyc = 0;
    int  gz_step = -1, tevt_step = -1;
    int  acc_count = 0, wr_count = 0;
    int  last_acc_step = -1, last_acc_owner = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Round-robin over requesters that have something queued.
    function automatic int rr_choice();
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (rr_last + k) % NREQ;
            if (q[idx].size() > 0) return idx;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i]        = (gap_left[i] == 0);
                req_data[8*i +: 8]  = q[i][0][7:0];
                req_last[i]         = q[i][0][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    // One clock: check registered outputs, update busy/gap models, drive, observe handshake.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            exp_wr = 0; in_msg = 0; rr_last = NREQ - 1; gz_step = -1; tevt_step = -1;
            check("grant_in_reset", grant, 0);
        end
        check("uart_wr", uart_wr, exp_wr);
        if (exp_wr) check("tx_data", uart_tx_data, exp_data);
        if (uart_wr) begin
            check("wr_while_busy", uart_busy, 0);
            wire_q.push_back(uart_tx_data);
            wr_count++;
        end
        check("timeout_evt", timeout_evt, (cyc == tevt_step));
        if (cyc == tevt_step) begin
            in_msg  = 0;
            rr_last = msg_owner;
        end
        if (cyc == gz_step) check("grant_release", grant, 0);

        if (uart_wr) begin
            if (rand_busy) busy_len = $urandom_range(0, 6);
            busy_left = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        uart_busy = (busy_left != 0);
        for (int i = 0; i < NREQ; i++) if (gap_left[i] > 0) gap_left[i]--;
        drive_inputs();
        #1;

        if (uart_busy || reset) check("ready_gated", req_ready, 0);
        check("ready_single", ($countones(req_ready) <= 1), 1);
        if (in_msg) check("ready_owner_only", 32'(req_ready) & ~(32'd1 << msg_owner), 0);
        exp_wr = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                if (in_msg) check("owner_locked", i, msg_owner);
                else        check("rr_owner", i, rr_choice());
                check("grant_at_accept", grant, 32'd1 << i);
                exp_wr   = 1;
                exp_data = q[i][0][7:0];
                if (q[i][0][8]) begin
                    in_msg  = 0;
                    rr_last = i;
                    gz_step = cyc + 2;
                end else begin
                    in_msg    = 1;
                    msg_owner = i;
                    if (rand_gaps) gap_left[i] = $urandom_range(0, max_gap);
                end
                void'(q[i].pop_front());
                acc_count++;
                last_acc_step  = cyc;
                last_acc_owner = i;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic wait_accept(input int budget);
        int target;
        int n;
        target = acc_count + 1;
        n = 0;
        while (acc_count < target && n < budget) begin
            step();
            n++;
        end
        check("accept_wait", acc_count, target);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q[0].size() > 0 || q[1].size() > 0 || busy_left != 0 || exp_wr || in_msg) && n < budget) begin
            step();
            n++;
        end
        check("drain_budget", (n < budget), 1);
    endtask

    initial begin
        int s, w0, pushed, len;
        logic [7:0] exp_order [8];
        logic [7:0] rb;

        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; uart_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) gap_left[i] = 0;

        // Reset state.
        do_reset();
        check("rst_grant", grant, 0);
        check("rst_wr", uart_wr, 0);
        check("rst_data", uart_tx_data, 0);
        check("rst_tevt", timeout_evt, 0);
        check("rst_ready", req_ready, 0);

        // Single byte 0x55 with busy held 20 cycles after the write.
        busy_len = 20;
        q[0].push_back(9'h155);
        wait_accept(20);
        s = last_acc_step;
        step();
        check("t1_wr", uart_wr, 1);
        check("t1_data", uart_tx_data, 8'h55);
        step();
        check("t1_grant0", grant, 0);
        drain(100);

        // Contention: two 3-byte messages, then a second round.
        busy_len = 3;
        wire_q.delete();
        do_reset();
        q[0].push_back(9'h0A0); q[0].push_back(9'h0A1); q[0].push_back(9'h1A2);
        q[1].push_back(9'h0B0); q[1].push_back(9'h0B1); q[1].push_back(9'h1B2);
        drain(200);
        q[0].push_back(9'h1C0);
        q[1].push_back(9'h1D0);
        drain(100);
        exp_order[0] = 8'hA0; exp_order[1] = 8'hA1; exp_order[2] = 8'hA2;
        exp_order[3] = 8'hB0; exp_order[4] = 8'hB1; exp_order[5] = 8'hB2;
        exp_order[6] = 8'hC0; exp_order[7] = 8'hD0;
        check("t2_count", wire_q.size(), 8);
        for (int k = 0; k < 8 && k < wire_q.size(); k++) check("t2_order", wire_q[k], exp_order[k]);

        // Busy pacing: 100 busy cycles after each write.
        busy_len = 100;
        w0 = wr_count;
        q[0].push_back(9'h011); q[0].push_back(9'h022); q[0].push_back(9'h133);
        drain(1000);
        check("t3_wr_per_byte", wr_count - w0, 3);

        // Timeout: req0 sends a non-last byte and goes quiet, req1 waits.
        busy_len = 2;
        do_reset();
        q[0].push_back(9'h044);
        q[1].push_back(9'h1EE);
        wait_accept(20);
        s = last_acc_step;
        check("t4_first_owner", last_acc_owner, 0);
        tevt_step = s + 18;
        while (cyc < s + 18) step();
        check("t4_evt_now", timeout_evt, 1);
        check("t4_grant_rel", grant, 0);
        step();
        check("t4_grant_req1", grant, 2'b10);
        drain(100);

        // Edge: req0 resumes when the counter reads 15; the lock survives.
        do_reset();
        q[0].push_back(9'h021); q[0].push_back(9'h122);
        q[1].push_back(9'h1EF);
        wait_accept(20);
        s = last_acc_step;
        gap_left[0] = 17;
        while (cyc < s + 17) step();
        check("t5_resume_step", last_acc_step, s + 17);
        check("t5_resume_owner", last_acc_owner, 0);
        check("t5_grant_kept", grant, 2'b01);
        drain(100);

        // Reset during GUARD.
        busy_len = 20;
        do_reset();
        q[0].push_back(9'h031); q[0].push_back(9'h132);
        q[1].push_back(9'h1BB);
        wait_accept(20);
        step();
        check("t6_guard_wr", uart_wr, 1);
        reset = 1'b1;
        step();
        check("t6_wr_cleared", uart_wr, 0);
        check("t6_grant_cleared", grant, 0);
        step();
        reset = 1'b0;
        wait_accept(60);
        check("t6_first_owner", last_acc_owner, 0);
        check("t6_first_byte", exp_data, 8'h32);
        drain(200);

        // Randomized message mix with mid-message gaps and random busy lengths.
        do_reset();
        rand_busy = 1; rand_gaps = 1; max_gap = 10;
        w0 = wr_count;
        pushed = 0;
        for (int i = 0; i < NREQ; i++) begin
            for (int m = 0; m < 25; m++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    rb = 8'($urandom_range(0, 255));
                    q[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, rb});
                    pushed++;
                end
            end
        end
        drain(20000);
        check("t7_bytes", wr_count - w0, pushed);
        rand_busy = 0; rand_gaps = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one buart transmitter between NREQ byte-stream requesters.
- Round-robin arbitration; the grant is locked per message, so bytes from different requesters never interleave on the wire.
- Sits between client blocks (CPU console, debug monitor, loaders) and the buart wr/tx_data/busy interface.
- Paces writes against buart busy and releases a lock whose owner goes silent mid-message.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LOCK_TIMEOUT, 65535, idle cycles of a locked owner with req_valid low before the lock is forcibly released (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester byte valid.
- req_data  input  8*NREQ  per-requester byte; requester i uses bits [8*i+7:8*i].
- req_last  input  NREQ  marks the final byte of a message; sampled with the byte.
- req_ready  output  NREQ  byte accepted this cycle when req_valid[i] & req_ready[i].
- grant  output  NREQ  one-hot current lock owner; all zero when idle.
- uart_wr  output  1  one-cycle write strobe to buart wr.
- uart_tx_data  output  8  byte to buart tx_data; valid while uart_wr=1.
- uart_busy  input  1  buart busy.
- timeout_evt  output  1  one-cycle pulse when a lock is released by timeout.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - state=IDLE, grant=0, uart_wr=0, uart_tx_data=0, timeout_evt=0, timeout counter=0.
  - Round-robin pointer last_owner=NREQ-1, so requester 0 has first priority.
  - req_ready is combinational and therefore 0 while in reset/IDLE.
- States: IDLE, LOAD, GUARD.
- IDLE:
  - If any req_valid: owner <= first set bit searching from (last_owner+1) mod NREQ upward with wrap.
  - grant <= onehot(owner); counter <= 0; next state LOAD.
  - No byte is accepted in the arbitration cycle.
- LOAD:
  - req_ready[owner] = !uart_busy; all other req_ready bits = 0.
  - Transfer (req_valid[owner] & !uart_busy):
    - next cycle uart_wr=1, uart_tx_data=captured byte;
    - last_flag <= req_last[owner]; counter <= 0; next state GUARD.
  - req_valid[owner]=0: counter increments. On reaching LOCK_TIMEOUT:
    - grant <= 0, last_owner <= owner, timeout_evt pulses one cycle, next state IDLE.
  - uart_busy=1 with req_valid high: wait; counter holds.
- GUARD (exactly 1 cycle, covers the one-cycle lag between wr and busy rising):
  - uart_wr returns to 0 next cycle.
  - If last_flag: grant <= 0, last_owner <= owner, next state IDLE. Otherwise next state LOAD.
- Latency: req accept at cycle T -> uart_wr high in T+1. Next accept no earlier than T+2, and only once busy is low.
- Maximum throughput is the line rate. The arbitration cost is 2 cycles (GUARD + IDLE) between messages.
- uart_wr is never asserted while uart_busy=1.
- req_valid of non-owners is ignored while locked. Fairness is applied only at message boundaries.
- Owner drops req_valid mid-message and resumes before timeout: the lock is kept and the counter resets on the transfer.
- Timeout in the same cycle a byte arrives: the transfer wins and the counter clears.
- Single requester, back-to-back messages: regrant to the same requester after the IDLE cycle.
- Reset mid-byte: uart_wr is forced 0. A byte already handed to buart completes on the line (buart is not reset by this block). After reset the arbiter waits only on uart_busy.
- Counter width is $clog2(LOCK_TIMEOUT+1); it saturates and never wraps.

Test Plan:
- Single byte: reset, req0 sends 0x55 with last=1, busy model high for 20 cycles after wr -> uart_wr exactly 1 cycle after accept with data 0x55; grant returns to 0 two cycles after accept.
- Contention: req0 and req1 both valid from reset, each sending a 3-byte message -> order A0,A1,A2,B0,B1,B2; no interleave; next contention grants req0 again only after req1 has been served.
- Busy pacing: hold uart_busy high for 100 cycles after each wr -> req_ready stays low throughout; exactly one uart_wr per byte; uart_wr never coincides with busy=1.
- Timeout: LOCK_TIMEOUT=16; req0 sends a non-last byte, then goes idle while req1 waits -> timeout_evt pulses 16 cycles after the counter starts; req1 is granted in the following cycle.
- Edge timeout: req0 resumes exactly on the cycle the counter reaches 15 -> byte accepted, no timeout_evt, lock kept.
- Reset mid-message: assert reset during GUARD -> uart_wr=0 and grant=0 next cycle; after release, req0 is first priority.
